// File: rtl/crc_tx_pkg.sv
// Shared types and constants for the crc_tx serializer.
// USB CRC polynomials and the receiver residuals they leave behind.
package crc_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } state_t;

  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;

  // Index of the final bit to send from a byte; a short last byte ends early.
  function automatic logic [2:0] last_bit_idx(input logic last, input logic [2:0] nbits);
    return (last && (nbits != 3'd0)) ? (nbits - 3'd1) : 3'd7;
  endfunction

endpackage

// File: rtl/crc_tx_lfsr.sv
// CRC shift register: accumulates over payload bits, then shifts itself out.
// Only the MSB leaves the block; it is both the feedback tap and the serial CRC bit.
module crc_tx_lfsr
  import crc_tx_pkg::*;
#(
  parameter int               NBITS      = 16,
  parameter logic [NBITS-1:0] POLYNOMIAL = CRC16_POLY
) (
  input  logic clk,
  input  logic n_rst,
  input  logic init,
  input  logic shift_data,
  input  logic data_bit,
  input  logic shift_out,
  output logic crc_msb
);

  logic [NBITS-1:0] r_crc;
  logic             w_flip;

  assign w_flip  = data_bit ^ r_crc[NBITS-1];
  assign crc_msb = r_crc[NBITS-1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_crc <= '1;
    end else if (init) begin
      r_crc <= '1;
    end else if (shift_data) begin
      r_crc <= {r_crc[NBITS-2:0], 1'b0} ^ (w_flip ? POLYNOMIAL : '0);
    end else if (shift_out) begin
      r_crc <= {r_crc[NBITS-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/crc_tx.sv
// USB transmit CRC generator/serializer: payload LSB-first, then ~CRC MSB-first.
// Optional feature macro CRC_TX_ABORT_EN adds an `abort` input that drops the packet.
module crc_tx
  import crc_tx_pkg::*;
#(
  parameter int               NBITS      = 16,
  parameter logic [NBITS-1:0] POLYNOMIAL = CRC16_POLY
) (
  input  logic       clk,
  input  logic       n_rst,
`ifdef CRC_TX_ABORT_EN
  input  logic       abort,
`endif
  input  logic       bit_tick,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic [2:0] in_nbits,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx_bit,
  output logic       tx_valid,
  output logic       done,
  output logic       underrun
);

  localparam int             CW       = $clog2(NBITS);
  localparam logic [CW-1:0]  CRC_LAST = CW'(NBITS - 1);

  state_t        r_state, w_next;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitcnt, r_end_idx;
  logic          r_shift_last;
  logic          r_hold_vld, r_hold_last;
  logic [7:0]    r_hold_data;
  logic [2:0]    r_hold_nbits;
  logic          r_last_acc;
  logic [CW-1:0] r_crccnt;
  logic          r_done, r_underrun;

  logic w_abort, w_ready, w_byte_end, w_tx_bit, w_crc_msb;
  logic w_load_in, w_load_hold, w_hold_wr, w_advance;
  logic w_crc_init, w_crc_data, w_crc_out, w_set_done, w_set_und;

`ifdef CRC_TX_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_byte_end = (r_bitcnt == r_end_idx);
  assign w_tx_bit   = (r_state == DATA) ? r_shift[0] :
                      (r_state == CRC)  ? ~w_crc_msb : 1'b0;

  assign in_ready = w_ready && !w_abort;
  assign tx_bit   = w_tx_bit;
  assign tx_valid = (r_state != IDLE);
  assign done     = r_done;
  assign underrun = r_underrun;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_load_in   = 1'b0;
    w_load_hold = 1'b0;
    w_hold_wr   = 1'b0;
    w_advance   = 1'b0;
    w_crc_init  = 1'b0;
    w_crc_data  = 1'b0;
    w_crc_out   = 1'b0;
    w_set_done  = 1'b0;
    w_set_und   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready    = 1'b1;
        w_crc_init = 1'b1;
        if (in_valid) begin
          w_load_in = 1'b1;
          w_next    = DATA;
        end
      end
      DATA: begin
        w_ready = !r_hold_vld && !r_last_acc;
        if (bit_tick) begin
          w_crc_data = 1'b1;
          if (!w_byte_end)            w_advance   = 1'b1;
          else if (r_shift_last)      w_next      = CRC;
          else if (r_hold_vld)        w_load_hold = 1'b1;
          // a byte arriving exactly as the shifter empties bypasses the holding register
          else if (in_valid && w_ready) w_load_in = 1'b1;
          else begin
            w_next    = IDLE;
            w_set_und = 1'b1;
          end
        end
        if (in_valid && w_ready && !w_load_in) w_hold_wr = 1'b1;
      end
      CRC: begin
        if (bit_tick) begin
          w_crc_out = 1'b1;
          if (r_crccnt == CRC_LAST) begin
            w_next     = IDLE;
            w_set_done = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
    if (w_abort) begin
      w_next      = IDLE;
      w_load_in   = 1'b0;
      w_load_hold = 1'b0;
      w_hold_wr   = 1'b0;
      w_advance   = 1'b0;
      w_crc_data  = 1'b0;
      w_crc_out   = 1'b0;
      w_crc_init  = 1'b1;
      w_set_done  = 1'b0;
      w_set_und   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bitcnt     <= '0;
      r_end_idx    <= 3'd7;
      r_shift_last <= 1'b0;
      r_hold_vld   <= 1'b0;
      r_last_acc   <= 1'b0;
      r_crccnt     <= '0;
      r_done       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_done     <= w_set_done;
      r_underrun <= w_set_und;
      if (w_load_in) begin
        r_bitcnt     <= '0;
        r_end_idx    <= last_bit_idx(in_last, in_nbits);
        r_shift_last <= in_last;
      end else if (w_load_hold) begin
        r_bitcnt     <= '0;
        r_end_idx    <= last_bit_idx(r_hold_last, r_hold_nbits);
        r_shift_last <= r_hold_last;
      end else if (w_advance) begin
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (w_abort)          r_hold_vld <= 1'b0;
      else if (w_hold_wr)   r_hold_vld <= 1'b1;
      else if (w_load_hold) r_hold_vld <= 1'b0;
      if (r_state == IDLE || w_abort)            r_last_acc <= w_load_in && in_last;
      else if ((w_hold_wr || w_load_in) && in_last) r_last_acc <= 1'b1;
      if (r_state != CRC) r_crccnt <= '0;
      else if (w_crc_out) r_crccnt <= r_crccnt + 1'b1;
    end
  end

  // payload bytes carry no reset; control state decides when they are meaningful
  always_ff @(posedge clk) begin
    if (w_load_in)        r_shift <= in_data;
    else if (w_load_hold) r_shift <= r_hold_data;
    else if (w_advance)   r_shift <= {1'b0, r_shift[7:1]};
    if (w_hold_wr) begin
      r_hold_data  <= in_data;
      r_hold_last  <= in_last;
      r_hold_nbits <= in_nbits;
    end
  end

  crc_tx_lfsr #(
    .NBITS      (NBITS),
    .POLYNOMIAL (POLYNOMIAL)
  ) u_lfsr (
    .clk        (clk),
    .n_rst      (n_rst),
    .init       (w_crc_init),
    .shift_data (w_crc_data),
    .data_bit   (w_tx_bit),
    .shift_out  (w_crc_out),
    .crc_msb    (w_crc_msb)
  );

endmodule

// File: tb/tb_crc_tx.sv
// Self-checking bench for crc_tx: vector table, hand sequences, random packets.
// CRC expectations come from mod-2 long division of the bit stream.
module tb_crc_tx;
  import crc_tx_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst, bit_tick, in_last, in_valid, abort_drv, sel5;
  logic [7:0] in_data;
  logic [2:0] in_nbits;

  logic tick16, valid16, abort16, rdy16, bit16, tv16, done16, und16;
  logic tick5, valid5, rdy5, bit5, tv5, done5, und5;
  logic o_ready, o_bit, o_tv, o_done, o_und;

  assign tick16  = bit_tick & ~sel5;
  assign valid16 = in_valid & ~sel5;
  assign abort16 = abort_drv & ~sel5;
  assign tick5   = bit_tick & sel5;
  assign valid5  = in_valid & sel5;
  assign o_ready = sel5 ? rdy5 : rdy16;
  assign o_bit   = sel5 ? bit5 : bit16;
  assign o_tv    = sel5 ? tv5 : tv16;
  assign o_done  = sel5 ? done5 : done16;
  assign o_und   = sel5 ? und5 : und16;

  crc_tx #(.NBITS(16), .POLYNOMIAL(16'h8005)) u_dut16 (
    .clk(clk), .n_rst(n_rst),
`ifdef CRC_TX_ABORT_EN
    .abort(abort16),
`endif
    .bit_tick(tick16), .in_data(in_data), .in_last(in_last), .in_nbits(in_nbits),
    .in_valid(valid16), .in_ready(rdy16), .tx_bit(bit16), .tx_valid(tv16),
    .done(done16), .underrun(und16));

  crc_tx #(.NBITS(5), .POLYNOMIAL(5'h05)) u_dut5 (
    .clk(clk), .n_rst(n_rst),
`ifdef CRC_TX_ABORT_EN
    .abort(1'b0),
`endif
    .bit_tick(tick5), .in_data(in_data), .in_last(in_last), .in_nbits(in_nbits),
    .in_valid(valid5), .in_ready(rdy5), .tx_bit(bit5), .tx_valid(tv5),
    .done(done5), .underrun(und5));

  typedef struct {
    logic [31:0] bytes;
    int          n;
    int          nbits;
    bit          last;
    int          tick;
    int          exp_len;
    int          exp_done;
    int          exp_und;
    int          exp_tv;
  } vec_t;

  logic [7:0]  pk_bytes[$];
  int          pk_nbits;
  bit          pk_last;
  int          cur_n;
  logic [15:0] cur_poly;
  bit          rx_bits[$];
  bit          exp_bits[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          seen_done, seen_und, tv_cycles;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Remainder of the stream (with all-ones preset) divided by x^n + poly.
  function automatic logic [15:0] poly_rem(input bit msg[$]);
    bit a[$];
    logic [15:0] r;
    a = msg;
    for (int k = 0; k < cur_n; k++) a.push_back(1'b0);
    for (int k = 0; k < cur_n; k++) a[k] = ~a[k];
    for (int i = 0; i < msg.size(); i++)
      if (a[i])
        for (int k = 1; k <= cur_n; k++) a[i+k] = a[i+k] ^ cur_poly[cur_n-k];
    r = '0;
    for (int k = 0; k < cur_n; k++) r = {r[14:0], a[msg.size()+k]};
    return r;
  endfunction

  function automatic void build_expected();
    int nb;
    logic [15:0] r;
    exp_bits.delete();
    for (int i = 0; i < pk_bytes.size(); i++) begin
      nb = (pk_last && i == pk_bytes.size() - 1 && pk_nbits != 0) ? pk_nbits : 8;
      for (int b = 0; b < nb; b++) exp_bits.push_back(pk_bytes[i][b]);
    end
    if (pk_last) begin
      r = poly_rem(exp_bits);
      for (int k = cur_n - 1; k >= 0; k--) exp_bits.push_back(~r[k]);
    end
  endfunction

  // Called and returns at posedge+1. tick_per>0: periodic ticks, else random at tick_pct%.
  task automatic run_pkt(input int tick_per, input int tick_pct, input int stop_after);
    int idx, cyc, nexp;
    bit fin, want_end;
    idx = 0; cyc = 0; fin = 0;
    build_expected();
    nexp = exp_bits.size();
    rx_bits.delete();
    seen_done = 0; seen_und = 0; tv_cycles = 0;
    while (!fin) begin
      if (idx < pk_bytes.size()) begin
        in_valid = 1'b1;
        in_data  = pk_bytes[idx];
        in_last  = pk_last && (idx == pk_bytes.size() - 1);
        in_nbits = pk_nbits[2:0];
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      bit_tick = (tick_per > 0) ? ((cyc % tick_per) == 0) : ($urandom_range(99) < tick_pct);
      if (in_valid && o_ready) idx++;
      if (o_tv) tv_cycles++;
      if (bit_tick && o_tv) rx_bits.push_back(o_bit);
      want_end = (stop_after == 0) && bit_tick && o_tv && (rx_bits.size() == nexp);
      @(posedge clk); #1;
      cyc++;
      if (o_done) seen_done++;
      if (o_und) seen_und++;
      if (want_end) begin
        if (pk_last) check("done_after_last_tick", o_done, 1);
        else         check("underrun_after_last_bit", o_und, 1);
        check("tx_valid_low_at_end", o_tv, 0);
        check("in_ready_high_at_end", o_ready, 1);
      end
      if (o_done || o_und) fin = 1;
      if (stop_after > 0 && rx_bits.size() >= stop_after) fin = 1;
      if (cyc >= 6000) begin
        check("cycle_budget_expired", 1, 0);
        fin = 1;
      end
    end
    in_valid = 1'b0; in_last = 1'b0; bit_tick = 1'b0;
  endtask

  task automatic finish_checks(input int exp_len, input int exp_done, input int exp_und);
    int nmis;
    logic [15:0] want_res;
    repeat (3) begin
      @(posedge clk); #1;
      if (o_done) seen_done++;
      if (o_und) seen_und++;
    end
    check("stream_length", rx_bits.size(), exp_len);
    nmis = 0;
    for (int i = 0; i < rx_bits.size() && i < exp_bits.size(); i++)
      if (rx_bits[i] != exp_bits[i]) nmis++;
    check("stream_bits_wrong", nmis, 0);
    check("done_pulses", seen_done, exp_done);
    check("underrun_pulses", seen_und, exp_und);
    if (pk_last) begin
      want_res = (cur_n == 16) ? CRC16_RESIDUAL : {11'd0, CRC5_RESIDUAL};
      check("receiver_residual", poly_rem(rx_bits), want_res);
    end
  endtask

  task automatic load_pkt(input logic [31:0] bytes, input int n, input int nbits, input bit last);
    pk_bytes.delete();
    for (int i = 0; i < n; i++) pk_bytes.push_back(bytes[8*i +: 8]);
    pk_nbits = nbits;
    pk_last  = last;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'h03020100, 4, 0, 1'b1, 4, 48, 1, 0, -1};
    vecs[1] = '{32'h000000A5, 1, 0, 1'b0, 2,  8, 0, 1, -1};
    vecs[2] = '{32'hEFBEADDE, 4, 0, 1'b1, 1, 48, 1, 0, 48};
    vecs[3] = '{32'h000000FF, 1, 1, 1'b1, 3, 17, 1, 0, -1};
    vecs[4] = '{32'h00563412, 3, 5, 1'b1, 2, 37, 1, 0, -1};
    vecs[5] = '{32'h00000080, 2, 7, 1'b1, 1, 31, 1, 0, 31};
    vecs[6] = '{32'h00003C5A, 2, 0, 1'b0, 1, 16, 0, 1, 16};
    vecs[7] = '{32'h000000C3, 1, 4, 1'b1, 1, 20, 1, 0, 20};

    sel5 = 1'b0; in_valid = 1'b0; bit_tick = 1'b0; abort_drv = 1'b0;
    in_data = '0; in_last = 1'b0; in_nbits = '0;
    cur_n = 16; cur_poly = 16'h8005;
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_tx_valid", tv16, 0);
    check("reset_tx_bit", bit16, 0);
    check("reset_done", done16, 0);
    check("reset_underrun", und16, 0);
    check("reset_in_ready", rdy16, 1);
    check("reset_in_ready_crc5", rdy5, 1);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      load_pkt(vecs[i].bytes, vecs[i].n, vecs[i].nbits, vecs[i].last);
      run_pkt(vecs[i].tick, 0, 0);
      finish_checks(vecs[i].exp_len, vecs[i].exp_done, vecs[i].exp_und);
      if (vecs[i].exp_tv >= 0) check("tx_valid_contiguous_cycles", tv_cycles, vecs[i].exp_tv);
    end

    // CRC5 token: addr 0x15, endp 0xE
    sel5 = 1'b1; cur_n = 5; cur_poly = 16'h0005;
    load_pkt(32'h00000715, 2, 3, 1'b1);
    run_pkt(1, 0, 0);
    finish_checks(16, 1, 0);
    check("crc5_tx_valid_cycles", tv_cycles, 16);
    sel5 = 1'b0; cur_n = 16; cur_poly = 16'h8005;

    // reset while the CRC is being sent
    load_pkt(32'h03020100, 4, 0, 1'b1);
    run_pkt(1, 0, 40);
    check("pre_reset_in_crc_phase", o_tv, 1);
    n_rst = 1'b0;
    #1;
    check("midreset_tx_valid", tv16, 0);
    check("midreset_tx_bit", bit16, 0);
    check("midreset_in_ready", rdy16, 1);
    @(posedge clk); #1;
    check("midreset_done", done16, 0);
    check("midreset_underrun", und16, 0);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;
    run_pkt(2, 0, 0);
    finish_checks(48, 1, 0);

`ifdef CRC_TX_ABORT_EN
    load_pkt(32'h03020100, 4, 0, 1'b1);
    run_pkt(1, 0, 12);
    abort_drv = 1'b1;
    @(posedge clk); #1;
    abort_drv = 1'b0;
    check("abort_tx_valid", o_tv, 0);
    seen_done = 0; seen_und = 0;
    repeat (4) begin
      if (o_done) seen_done++;
      if (o_und) seen_und++;
      @(posedge clk); #1;
    end
    check("abort_no_done", seen_done, 0);
    check("abort_no_underrun", seen_und, 0);
    load_pkt(32'h07060504, 4, 0, 1'b1);
    run_pkt(3, 0, 0);
    finish_checks(48, 1, 0);
`endif

    for (int p = 0; p < 24; p++) begin
      int n, pct;
      bit last;
      n = $urandom_range(6, 1);
      last = (p % 4) != 3;
      pk_bytes.delete();
      for (int i = 0; i < n; i++) pk_bytes.push_back(8'($urandom_range(255)));
      pk_nbits = $urandom_range(7, 0);
      pk_last  = last;
      pct = $urandom_range(100, 25);
      run_pkt(0, pct, 0);
      finish_checks(exp_bits.size(), last ? 1 : 0, last ? 0 : 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_tx.md
# crc_tx

Transmit-side CRC generator and serializer for the USB packet path. It accepts payload bytes over a valid/ready handshake and shifts them out LSB-first, one bit per `bit_tick`, while accumulating a CRC. After the last payload bit it appends the complemented CRC, MSB first. A receiver-side CRC checker fed the full stream lands on its fixed residual.

## Interface
- `NBITS`, 16, CRC width (16 for data packets, 5 for tokens)
- `POLYNOMIAL`, 16'h8005, generator polynomial without the implicit x^NBITS term; bit 0 is always 1
- `clk` input 1 system clock
- `n_rst` input 1 asynchronous, active-low reset
- `bit_tick` input 1 one-cycle pulse from bit timing; consumes the current output bit
- `in_data` input 8 payload byte, LSB sent first
- `in_last` input 1 byte is the final payload byte
- `in_nbits` input 3 valid bits in the final byte (0 means 8); ignored unless `in_last`
- `in_valid` input 1 byte offered
- `in_ready` output 1 byte accepted when `in_valid && in_ready`
- `tx_bit` output 1 current serial bit
- `tx_valid` output 1 `tx_bit` is meaningful; high for the whole packet
- `done` output 1 one-cycle pulse after the final CRC bit is consumed
- `underrun` output 1 one-cycle pulse when payload ran dry before `in_last`

## Operation
- Datapath:
  - shift register (8 b), bit counter (3 b), one-byte holding register with its own last/nbits
  - CRC register (`NBITS`), CRC bit counter (clog2(`NBITS`))
- FSM states: IDLE, DATA, CRC.
- IDLE:
  - `in_ready`=1; the CRC register is held at all-ones.
  - An accepted byte loads the shift register and sets `tx_valid`=1 with `tx_bit`=bit 0. Next state is DATA.
- DATA, on each `bit_tick`:
  - Consume `tx_bit` d: flip = d ^ crc[NBITS-1], then crc = {crc[NBITS-2:0],0} ^ (flip ? POLYNOMIAL : 0).
  - Advance to the next bit.
  - When the byte's bits are exhausted (8, or `in_nbits` on the last byte):
    - reload from the holding register, or
    - if the byte was last, go to CRC, or
    - otherwise go to IDLE, pulsing `underrun` and dropping `tx_valid` with no CRC sent.
- `in_ready` in DATA = holding register empty and `in_last` not yet accepted.
- CRC state:
  - `tx_bit` = ~crc[NBITS-1]; each `bit_tick` shifts crc left and increments the counter.
  - After `NBITS` ticks: `tx_valid`=0, `done` pulses, return to IDLE, crc reset to all-ones.
  - `in_ready`=0 throughout CRC.
- Simultaneous events:
  - A holding-register write in the same cycle that the shift register empties is forwarded directly into the shift register, so no underrun occurs.
  - A `bit_tick` in IDLE is ignored.
  - `in_valid` with `in_last`=1, `in_nbits`=1 yields a one-bit final byte.

## Timing
- Reset values:
  - `tx_valid`=0, `tx_bit`=0, `done`=0, `underrun`=0
  - `in_ready`=1 (IDLE), crc=all-ones, all counters 0
- Latency from the IDLE accept edge to `tx_valid`=1 is 1 cycle.
- Bits change only on the cycle after `bit_tick`.
- Packet length in bits is 8·(bytes−1) + nbits_last + `NBITS`.
- `done` is asserted the cycle after the tick that consumes the last CRC bit.
- With `bit_tick` every cycle and a continuously valid source there are no idle gaps between bytes.
- Reset mid-packet: immediate return to reset values; no `done` or `underrun` is emitted.

## Configuration
- `CRC_TX_ABORT_EN` defined:
  - Adds an input port `abort` (1 b).
  - `abort`=1 in any state moves to IDLE next cycle, clears the holding register, sets `tx_valid`=0 and re-initialises crc.
  - Emits neither `done` nor `underrun`.
- Undefined: no `abort` port; a packet ends only via `done`, `underrun` or reset.

## Structure
- Package `crc_tx_pkg`:
  - state enum (IDLE, DATA, CRC)
  - constants CRC16_POLY=16'h8005, CRC16_RESIDUAL=16'h800D, CRC5_POLY=5'h05, CRC5_RESIDUAL=5'h0C
- Sub-module `crc_tx_lfsr` (`NBITS`, `POLYNOMIAL`) holds the CRC register with `init`, `shift_data` (with data bit) and `shift_out` controls.

## Test plan
- CRC16, bytes 00 01 02 03, last nbits=0, tick every 4 cycles:
  - 48 bits out; first 32 bits equal the data LSB-first.
  - A receiver checker fed the stream ends at residual 16'h800D.
  - `done` pulses 1 cycle after the 48th tick.
- NBITS=5, POLYNOMIAL=5'h05, bytes 0x15 then 0x07 with last nbits=3 (token addr 0x15, endp 0xE):
  - 16 bits out; the receiver checker ends at 5'h0C.
- Underrun: one byte 0xA5 without `in_last`, then no further `in_valid`:
  - 8 bits out (1,0,1,0,0,1,0,1), then `underrun` pulse, `tx_valid`=0, `in_ready`=1.
- Back-to-back: 4 bytes with `in_valid` held and `bit_tick` every cycle:
  - continuous `tx_valid`; `in_ready` low only while the holding register is full; no underrun.
- Reset asserted during the CRC phase:
  - outputs return to reset values.
  - The following 00 01 02 03 packet still reaches the 16'h800D residual.
- With `CRC_TX_ABORT_EN`, `abort` during byte 2:
  - `tx_valid`=0 next cycle, no `done`.
  - The next packet is correct.
